// File: rtl/int_multiplier_pkg.sv
// Shared definitions for the iterative integer multiplier: M-extension
// op codes, FSM state type and operand signedness classes.
// Optional feature macro used by the top: INT_MUL_REUSE_EN.

`ifndef INT_MULTIPLIER_OPS
`define INT_MULTIPLIER_OPS
`define MUL    2'b00
`define MULH   2'b01
`define MULHSU 2'b10
`define MULHU  2'b11
`endif

package int_multiplier_pkg;

    localparam logic [1:0] OP_MUL    = `MUL;
    localparam logic [1:0] OP_MULH   = `MULH;
    localparam logic [1:0] OP_MULHSU = `MULHSU;
    localparam logic [1:0] OP_MULHU  = `MULHU;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Signedness class of the operand pair: both unsigned, signed x unsigned,
    // or both signed.
    typedef enum logic [1:0] {
        CLS_UU = 2'd0,
        CLS_SU = 2'd1,
        CLS_SS = 2'd2
    } op_class_t;

    function automatic op_class_t op_class(input logic [1:0] op_code);
        op_class_t cls;
        case (op_code)
            OP_MULH:   cls = CLS_SS;
            OP_MULHSU: cls = CLS_SU;
            default:   cls = CLS_UU;
        endcase
        return cls;
    endfunction

    // rs1 is treated as signed for MULH and MULHSU.
    function automatic logic a_is_signed(input logic [1:0] op_code);
        return (op_code == OP_MULH) || (op_code == OP_MULHSU);
    endfunction

    // rs2 is treated as signed for MULH only.
    function automatic logic b_is_signed(input logic [1:0] op_code);
        return (op_code == OP_MULH);
    endfunction

endpackage

// File: rtl/int_mul_step.sv
// One radix-2^M step: adds the multiplicand times an M-bit chunk of the
// multiplier onto the running upper half of the product.

module int_mul_step #(
    parameter int N = 32,
    parameter int M = 8
) (
    input  logic [N-1:0]   hi,
    input  logic [N-1:0]   a_mag,
    input  logic [M-1:0]   chunk,
    output logic [N+M-1:0] part
);

    // (2^N-1) + (2^N-1)*(2^M-1) < 2^(N+M), so the sum never overflows part.
    always_comb begin
        part = {{M{1'b0}}, hi} + ({{M{1'b0}}, a_mag} * {{N{1'b0}}, chunk});
    end

endmodule

// File: rtl/int_multiplier.sv
// Iterative radix-2^M multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are turned into magnitudes, M multiplier bits are retired per
// CALC cycle, and the 2N-bit product is sign-corrected at the output.
// Define INT_MUL_REUSE_EN to let a repeated operand pair skip recomputation.

module int_multiplier
    import int_multiplier_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_in,
    output logic         ready_out,
    output logic         valid_out,
    input  logic         ready_in,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    localparam int STEPS = N / M;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    state_t           state_q, state_d;
    logic             valid_out_q, valid_out_d;
    logic [2*N-1:0]   prod_q, prod_d;
    logic [N-1:0]     a_mag_q, a_mag_d;
    logic [1:0]       op_q, op_d;
    logic             sgn_q, sgn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             stall;
    logic             accept;
    logic             reuse_hit;
    logic             a_neg;
    logic             b_neg;
    logic [N-1:0]     a_mag_new;
    logic [N-1:0]     b_mag_new;
    logic [N+M-1:0]   part;
    logic [2*N-1:0]   prod_shift;
    logic [2*N-1:0]   full;

    assign stall     = (state_q != IDLE);
    assign ready_out = ready_in && !stall;
    assign accept    = valid_in && ready_out;

    assign a_neg     = a_is_signed(op) && a[N-1];
    assign b_neg     = b_is_signed(op) && b[N-1];
    assign a_mag_new = a_neg ? -a : a;
    assign b_mag_new = b_neg ? -b : b;

    int_mul_step #(
        .N(N),
        .M(M)
    ) u_step (
        .hi    (prod_q[2*N-1:N]),
        .a_mag (a_mag_q),
        .chunk (prod_q[M-1:0]),
        .part  (part)
    );

    // The new partial sum enters at the top while the consumed multiplier
    // chunk falls off the bottom; with M == N the partial sum is the whole product.
    generate
        if (M < N) begin : g_shift
            assign prod_shift = {part, prod_q[N-1:M]};
        end else begin : g_shift_full
            assign prod_shift = part;
        end
    endgenerate

`ifdef INT_MUL_REUSE_EN
    logic         prev_vld_q, prev_vld_d;
    logic [N-1:0] prev_a_q, prev_a_d;
    logic [N-1:0] prev_b_q, prev_b_d;
    op_class_t    prev_cls_q, prev_cls_d;

    // MUL's low half is the same for every signedness class, so it may reuse
    // any stored product; the high-half ops need a matching class.
    assign reuse_hit = prev_vld_q && (a == prev_a_q) && (b == prev_b_q) &&
                       ((op == OP_MUL) || (op_class(op) == prev_cls_q));

    // Remember the operands of every freshly computed product.
    always_comb begin
        prev_vld_d = prev_vld_q;
        prev_a_d   = prev_a_q;
        prev_b_d   = prev_b_q;
        prev_cls_d = prev_cls_q;
        if (accept && !reuse_hit) begin
            prev_vld_d = 1'b1;
            prev_a_d   = a;
            prev_b_d   = b;
            prev_cls_d = op_class(op);
        end
    end

    // Reuse tag registers; reset forgets any stored product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_vld_q <= 1'b0;
            prev_a_q   <= '0;
            prev_b_q   <= '0;
            prev_cls_q <= CLS_UU;
        end else begin
            prev_vld_q <= prev_vld_d;
            prev_a_q   <= prev_a_d;
            prev_b_q   <= prev_b_d;
            prev_cls_q <= prev_cls_d;
        end
    end
`else
    assign reuse_hit = 1'b0;
`endif

    // Next-state logic: accept loads operands (accept beats a same-cycle
    // consume), CALC retires one chunk per cycle, consume drops valid_out.
    always_comb begin
        state_d     = state_q;
        valid_out_d = valid_out_q;
        prod_d      = prod_q;
        a_mag_d     = a_mag_q;
        op_d        = op_q;
        sgn_d       = sgn_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d = op;
                    if (reuse_hit) begin
                        valid_out_d = 1'b1;
                    end else begin
                        a_mag_d     = a_mag_new;
                        sgn_d       = a_neg ^ b_neg;
                        prod_d      = {{N{1'b0}}, b_mag_new};
                        cnt_d       = '0;
                        valid_out_d = 1'b0;
                        state_d     = CALC;
                    end
                end else if (valid_out_q && ready_in) begin
                    valid_out_d = 1'b0;
                end
            end
            CALC: begin
                prod_d = prod_shift;
                if (cnt_q == LAST_STEP) begin
                    valid_out_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_out_q <= 1'b0;
            prod_q      <= '0;
            a_mag_q     <= '0;
            op_q        <= '0;
            sgn_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            valid_out_q <= valid_out_d;
            prod_q      <= prod_d;
            a_mag_q     <= a_mag_d;
            op_q        <= op_d;
            sgn_q       <= sgn_d;
            cnt_q       <= cnt_d;
        end
    end

    // Sign-correct the magnitude product and pick the half the op asks for.
    always_comb begin
        full = sgn_q ? -prod_q : prod_q;
        y    = (op_q == OP_MUL) ? full[N-1:0] : full[2*N-1:N];
    end

    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_int_multiplier.sv
// Self-checking bench for int_multiplier: directed corner cases plus random
// operands checked against a plain-arithmetic product model.

module tb_int_multiplier;
    import int_multiplier_pkg::*;

    localparam int N     = 32;
    localparam int M     = 8;
    localparam int STEPS = N / M;
    localparam int MAX_WAIT = 40;

    // Cycles from the accept edge until valid_out is seen after an edge.
    // A reused product is flagged at the accept edge itself and consumed one
    // edge later, so it shows up as 0 here.
`ifdef INT_MUL_REUSE_EN
    localparam int REUSE_LAT = 0;
`else
    localparam int REUSE_LAT = STEPS;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_in;
    logic         ready_out;
    logic         valid_out;
    logic         ready_in;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] y;

    int errors = 0;
    int checks = 0;

    int_multiplier #(
        .N(N),
        .M(M)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .op        (op),
        .a         (a),
        .b         (b),
        .y         (y)
    );

    always #5 clk = ~clk;

    // Extend each operand to 2N bits according to its signedness and keep
    // the exact product modulo 2^(2N).
    function automatic logic [N-1:0] ref_model(input logic [1:0] o, input logic [N-1:0] x,
                                               input logic [N-1:0] z);
        logic [2*N-1:0] ex;
        logic [2*N-1:0] ez;
        logic [2*N-1:0] p;
        ex = ((o == OP_MULH) || (o == OP_MULHSU)) ? {{N{x[N-1]}}, x} : {{N{1'b0}}, x};
        ez = (o == OP_MULH) ? {{N{z[N-1]}}, z} : {{N{1'b0}}, z};
        p  = ex * ez;
        return (o == OP_MUL) ? p[N-1:0] : p[2*N-1:N];
    endfunction

    // Issue one op with ready_in high and wait (bounded) for its result.
    task automatic run_op(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] z,
                          output logic [N-1:0] res, output int lat, output bit ro_bad,
                          output logic vo_at_accept);
        @(negedge clk);
        op = o;
        a = x;
        b = z;
        valid_in = 1'b1;
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        vo_at_accept = valid_out;
        ro_bad = 1'b0;
        lat = 0;
        while (valid_out !== 1'b1 && lat < MAX_WAIT) begin
            if (ready_out !== 1'b0) ro_bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        res = y;
        if (valid_out !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout op=%0d: valid_out=%b required 1", o, valid_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        op = OP_MUL;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid_out: got %b required 0", valid_out);
        end
        checks++;
        if (y !== '0) begin
            errors++;
            $display("[TB] FAIL reset_y: got %h required 0", y);
        end
        checks++;
        if (ready_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready_out: got %b required 1", ready_out);
        end
        ready_in = 1'b0;
        #1;
        checks++;
        if (ready_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready_gate: got %b required 0", ready_out);
        end
        @(negedge clk);
        reset = 1'b0;
        ready_in = 1'b1;
    endtask

    task automatic test_mul_basic();
        logic [N-1:0] res;
        int lat;
        bit ro_bad;
        logic vo0;
        run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, res, lat, ro_bad, vo0);
        checks++;
        if (res !== 32'hFFFF_FFEB) begin
            errors++;
            $display("[TB] FAIL mul_basic_y: got %h required ffffffeb", res);
        end
        checks++;
        if (lat != STEPS) begin
            errors++;
            $display("[TB] FAIL mul_basic_latency: got %0d required %0d", lat, STEPS);
        end
        checks++;
        if (ro_bad) begin
            errors++;
            $display("[TB] FAIL mul_basic_ready_out_calc: got 1 required 0");
        end
    endtask

    task automatic test_signed_variants();
        logic [1:0]   ops [3] = '{OP_MULHU, OP_MULHSU, OP_MULH};
        logic [N-1:0] exp [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
        logic [N-1:0] res;
        int lat;
        bit ro_bad;
        logic vo0;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, ro_bad, vo0);
            checks++;
            if (res !== exp[i]) begin
                errors++;
                $display("[TB] FAIL signed_op%0d_y: got %h required %h", ops[i], res, exp[i]);
            end
        end
    endtask

    task automatic test_boundary();
        logic [1:0]   ops [4] = '{OP_MULH, OP_MUL, OP_MULH, OP_MULHU};
        logic [N-1:0] xs  [4] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
        logic [N-1:0] zs  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        logic [N-1:0] exp [4] = '{32'h0000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        logic [N-1:0] res;
        int lat;
        bit ro_bad;
        logic vo0;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], xs[i], zs[i], res, lat, ro_bad, vo0);
            checks++;
            if (res !== exp[i]) begin
                errors++;
                $display("[TB] FAIL boundary%0d_y: got %h required %h", i, res, exp[i]);
            end
        end
        // Multiplying by zero still runs every step.
        checks++;
        if (lat != STEPS) begin
            errors++;
            $display("[TB] FAIL boundary_zero_latency: got %0d required %0d", lat, STEPS);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] specials [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF};
        logic [N-1:0] x;
        logic [N-1:0] z;
        logic [1:0]   o;
        logic [N-1:0] res;
        int lat;
        bit ro_bad;
        logic vo0;
        for (int i = 0; i < 32; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            z = $urandom;
            if (i % 4 == 0) x = specials[$urandom_range(0, 3)];
            run_op(o, x, z, res, lat, ro_bad, vo0);
            checks++;
            if (res !== ref_model(o, x, z)) begin
                errors++;
                $display("[TB] FAIL random%0d_y op=%0d a=%h b=%h: got %h required %h",
                         i, o, x, z, res, ref_model(o, x, z));
            end
            checks++;
            if (lat != STEPS) begin
                errors++;
                $display("[TB] FAIL random%0d_latency: got %0d required %0d", i, lat, STEPS);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] x1 = 32'hDEAD_BEEF;
        logic [N-1:0] z1 = 32'h0BAD_F00D;
        logic [N-1:0] x2 = 32'h1357_9BDF;
        logic [N-1:0] z2 = 32'hFEDC_BA98;
        logic [N-1:0] held;
        int lat;
        @(negedge clk);
        op = OP_MULHSU;
        a = x1;
        b = z1;
        valid_in = 1'b1;
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        lat = 0;
        while (valid_out !== 1'b1 && lat < MAX_WAIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        held = y;
        checks++;
        if (valid_out !== 1'b1 || held !== ref_model(OP_MULHSU, x1, z1)) begin
            errors++;
            $display("[TB] FAIL bp_first_y: got %h valid %b required %h valid 1",
                     held, valid_out, ref_model(OP_MULHSU, x1, z1));
        end
        // A new request must be ignored while the result is held.
        op = OP_MUL;
        a = x2;
        b = z2;
        valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (valid_out !== 1'b1 || y !== held || ready_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got valid %b y %h ready_out %b required 1 %h 0",
                         i, valid_out, y, ready_out, held);
            end
        end
        // Consume and accept in the same edge: the accept wins.
        @(negedge clk);
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_accept_wins: got valid_out %b required 0", valid_out);
        end
        lat = 0;
        while (valid_out !== 1'b1 && lat < MAX_WAIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (y !== ref_model(OP_MUL, x2, z2) || lat != STEPS) begin
            errors++;
            $display("[TB] FAIL bp_second: got y %h lat %0d required %h lat %0d",
                     y, lat, ref_model(OP_MUL, x2, z2), STEPS);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [N-1:0] res;
        int lat;
        bit ro_bad;
        logic vo0;
        @(negedge clk);
        op = OP_MULH;
        a = 32'hCAFE_1234;
        b = 32'h8765_4321;
        valid_in = 1'b1;
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (valid_out !== 1'b0 || y !== '0 || ready_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_state: got valid %b y %h ready_out %b required 0 0 1",
                     valid_out, y, ready_out);
        end
        @(negedge clk);
        reset = 1'b0;
        run_op(OP_MUL, 32'd3, 32'd5, res, lat, ro_bad, vo0);
        checks++;
        if (res !== 32'd15 || lat != STEPS) begin
            errors++;
            $display("[TB] FAIL midreset_next: got y %h lat %0d required f lat %0d", res, lat, STEPS);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] x;
        logic [N-1:0] z;
        logic [1:0]   o;
        logic [N-1:0] res;
        int lat;
        bit ro_bad;
        logic vo0;
        for (int i = 0; i < 6; i++) begin
            o = 2'(i % 4);
            x = $urandom;
            z = $urandom;
            run_op(o, x, z, res, lat, ro_bad, vo0);
            checks++;
            if (res !== ref_model(o, x, z) || vo0 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b%0d: got y %h valid_after_accept %b required %h 0",
                         i, res, vo0, ref_model(o, x, z));
            end
        end
    endtask

    task automatic test_reuse();
        logic [N-1:0] x;
        logic [N-1:0] z;
        logic [N-1:0] res;
        int lat;
        bit ro_bad;
        logic vo0;
        x = $urandom | 32'h8000_0000;
        z = $urandom | 32'h8000_0000;
        run_op(OP_MULH, x, z, res, lat, ro_bad, vo0);
        checks++;
        if (res !== ref_model(OP_MULH, x, z)) begin
            errors++;
            $display("[TB] FAIL reuse_mulh_y: got %h required %h", res, ref_model(OP_MULH, x, z));
        end
        run_op(OP_MUL, x, z, res, lat, ro_bad, vo0);
        checks++;
        if (res !== ref_model(OP_MUL, x, z) || lat != REUSE_LAT) begin
            errors++;
            $display("[TB] FAIL reuse_mul: got y %h lat %0d required %h lat %0d",
                     res, lat, ref_model(OP_MUL, x, z), REUSE_LAT);
        end
        run_op(OP_MULHU, x, z, res, lat, ro_bad, vo0);
        checks++;
        if (res !== ref_model(OP_MULHU, x, z) || lat != STEPS) begin
            errors++;
            $display("[TB] FAIL reuse_mulhu: got y %h lat %0d required %h lat %0d",
                     res, lat, ref_model(OP_MULHU, x, z), STEPS);
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_signed_variants();
        test_boundary();
        test_random();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        test_reuse();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
